seg_scan_decode: RTL

//  Receive-side counterpart of the 7-segment encoder. Snoops a multiplexed display bus
//  (segment pattern + one-hot digit select), waits for each pattern to settle, maps it

---
 rtl/seg_scan_decode_pkg.sv | 35 +++
 rtl/seg_scan_decode_if.sv | 32 +++
 rtl/seg_scan_decode_lookup.sv | 32 +++
 rtl/seg_scan_decode.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_decode_pkg.sv
// Shared definitions for the 7-segment scan decoder.
//   - Segment pattern constants (bit order g,f,e,d,c,b,a; 1 = lit), the same
//     values the matching encoder drives.
//   - Alternate 7/9 glyphs, the "unrecognised" BCD code and the blank pattern.
//   - Lookup result record and the frame FSM state type.
package seg_scan_decode_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h27;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_ALT_7 = 7'h07;
    localparam logic [6:0] SEG_ALT_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef struct packed {
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } lookup_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_decode_if.sv
// Display-bus snoop interface for seg_scan_decode.
//   seg_in      : segment pattern, bit7 = dp, bits6:0 = g..a
//   digit_sel   : one-hot digit enable
//   bcd_out     : published BCD digits, digit i in [4i+3:4i]
//   blank_out   : per-digit "dark" flag
//   dp_out      : per-digit captured decimal point
//   frame_err   : some digit of the published frame was unrecognised
//   frame_valid : one-cycle pulse when the outputs above update
//   sel_err     : one-cycle pulse when a stable digit_sel was not one-hot
// master = display side / stimulus, slave = decoder.
interface seg_scan_decode_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7:0]              seg_in;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   blank_out;
    logic [NUM_DIGITS-1:0]   dp_out;
    logic                    frame_err;
    logic                    frame_valid;
    logic                    sel_err;

    modport master (
        output seg_in, digit_sel,
        input  bcd_out, blank_out, dp_out, frame_err, frame_valid, sel_err
    );

    modport slave (
        input  seg_in, digit_sel,
        output bcd_out, blank_out, dp_out, frame_err, frame_valid, sel_err
    );
endinterface

// File: rtl/seg_scan_decode_lookup.sv
// Combinational 7-segment pattern to BCD lookup.
//   pattern_i : segments g..a (dp excluded, it never affects the decode)
//   result_o  : {bcd, blank, err}; dark pattern -> bcd 0 + blank,
//               anything unknown -> BCD_BAD + err
module seg_pattern_lookup
    import seg_scan_decode_pkg::*;
(
    input  logic [6:0] pattern_i,
    output lookup_t    result_o
);

    always_comb begin
        result_o = '{bcd: BCD_BAD, blank: 1'b0, err: 1'b1};
        case (pattern_i)
            SEG_0:     result_o = '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
            SEG_1:     result_o = '{bcd: 4'd1, blank: 1'b0, err: 1'b0};
            SEG_2:     result_o = '{bcd: 4'd2, blank: 1'b0, err: 1'b0};
            SEG_3:     result_o = '{bcd: 4'd3, blank: 1'b0, err: 1'b0};
            SEG_4:     result_o = '{bcd: 4'd4, blank: 1'b0, err: 1'b0};
            SEG_5:     result_o = '{bcd: 4'd5, blank: 1'b0, err: 1'b0};
            SEG_6:     result_o = '{bcd: 4'd6, blank: 1'b0, err: 1'b0};
            SEG_7:     result_o = '{bcd: 4'd7, blank: 1'b0, err: 1'b0};
            SEG_ALT_7: result_o = '{bcd: 4'd7, blank: 1'b0, err: 1'b0};
            SEG_8:     result_o = '{bcd: 4'd8, blank: 1'b0, err: 1'b0};
            SEG_9:     result_o = '{bcd: 4'd9, blank: 1'b0, err: 1'b0};
            SEG_ALT_9: result_o = '{bcd: 4'd9, blank: 1'b0, err: 1'b0};
            SEG_BLANK: result_o = '{bcd: 4'd0, blank: 1'b1, err: 1'b0};
            default:   result_o = '{bcd: BCD_BAD, blank: 1'b0, err: 1'b1};
        endcase
    end

endmodule

// File: rtl/seg_scan_decode.sv
// Multiplexed 7-segment display snooper: waits for each {digit_sel, seg_in}
// value to settle for STABLE_CYCLES samples, decodes it back to BCD, and
// publishes a complete frame once every digit has been captured.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears all state and outputs
//   bus   : seg_scan_decode_if.slave (see interface header for signals)
module seg_scan_decode
    import seg_scan_decode_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_decode_if.slave   bus
);

    localparam int IN_W  = NUM_DIGITS + 8;
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

    logic [IN_W-1:0]         in_d, in_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    same;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [7:0]              seg_q;
    logic                    sel_ok;
    logic [IDX_W-1:0]        idx;
    lookup_t                 lk;

    logic [4*NUM_DIGITS-1:0] sh_bcd_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_dp_q, sh_err_q;
    logic [NUM_DIGITS-1:0]   mask_d, mask_q;

    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   blank_q, dp_q;
    logic                    ferr_q, fv_q, se_q;
    state_t                  state_q;

    assign in_d  = {bus.digit_sel, bus.seg_in};
    assign same  = (in_d == in_q);
    assign sel_q = in_q[IN_W-1:8];
    assign seg_q = in_q[7:0];

    // Saturating run counter: it sits at CNT_MAX while the bus is held, so
    // the CNT_ARM -> CNT_MAX step happens exactly once per stable period.
    always_comb begin
        cnt_d = '0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign capture = same && (cnt_q == CNT_ARM);

    // One-hot check plus OR-encode of the set bit; the index is only used
    // when exactly one bit is set, so no priority logic is needed.
    assign sel_ok = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    seg_pattern_lookup u_lookup (
        .pattern_i (seg_q[6:0]),
        .result_o  (lk)
    );

    // Mask clears on the PUBLISH edge first, so a capture on that same edge
    // counts toward the next frame.
    always_comb begin
        mask_d = (state_q == PUBLISH) ? '0 : mask_q;
        if (capture && sel_ok) begin
            mask_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q       <= '0;
            cnt_q      <= '0;
            sh_bcd_q   <= '0;
            sh_blank_q <= '0;
            sh_dp_q    <= '0;
            sh_err_q   <= '0;
            mask_q     <= '0;
            bcd_q      <= '0;
            blank_q    <= '0;
            dp_q       <= '0;
            ferr_q     <= 1'b0;
            fv_q       <= 1'b0;
            se_q       <= 1'b0;
            state_q    <= COLLECT;
        end else begin
            in_q   <= in_d;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            se_q   <= capture && !sel_ok;
            fv_q   <= 1'b0;

            if (capture && sel_ok) begin
                sh_bcd_q[4*idx +: 4] <= lk.bcd;
                sh_blank_q[idx]      <= lk.blank;
                sh_dp_q[idx]         <= seg_q[7];
                sh_err_q[idx]        <= lk.err;
            end

            // Outputs load from the pre-edge shadow when entering PUBLISH,
            // so frame_valid is high for the whole PUBLISH cycle.
            case (state_q)
                COLLECT: begin
                    if (&mask_q) begin
                        bcd_q   <= sh_bcd_q;
                        blank_q <= sh_blank_q;
                        dp_q    <= sh_dp_q;
                        ferr_q  <= |sh_err_q;
                        fv_q    <= 1'b1;
                        state_q <= PUBLISH;
                    end
                end
                PUBLISH: state_q <= COLLECT;
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.blank_out   = blank_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_err   = ferr_q;
    assign bus.frame_valid = fv_q;
    assign bus.sel_err     = se_q;

endmodule
